// File: rtl/contador_param.sv
// WIDTH-bit up/down counter with step, load, hold and modulo-LIMIT modes; registered Q/RCO/LOAD.
// Optional macro CONTADOR_SAT_EN makes the step modes clamp at the rails instead of wrapping.
module contador_param #(
  parameter int WIDTH = 8,
  parameter int STEP  = 3
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic             ENABLE,
  input  logic [2:0]       MODO,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] LIMIT,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             LOAD
);

  typedef enum logic [2:0] {
    M_ADD_STEP = 3'b000,
    M_DEC      = 3'b001,
    M_INC      = 3'b010,
    M_LOAD     = 3'b011,
    M_SUB_STEP = 3'b100,
    M_HOLD     = 3'b101,
    M_MOD      = 3'b110,
    M_RSVD     = 3'b111
  } mode_e;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic             flag;  // wrapped, or clamped when saturation is built in
  } res_t;

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

  function automatic res_t add_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] inc);
    res_t           r;
    logic [WIDTH:0] sum;
    sum    = {1'b0, a} + {1'b0, inc};
    r.flag = sum[WIDTH];
`ifdef CONTADOR_SAT_EN
    r.q    = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
    r.q    = sum[WIDTH-1:0];
`endif
    return r;
  endfunction

  function automatic res_t sub_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] dec);
    res_t r;
    r.flag = (a < dec);
`ifdef CONTADOR_SAT_EN
    r.q    = r.flag ? '0 : a - dec;
`else
    r.q    = a - dec;
`endif
    return r;
  endfunction

  mode_e            mode;
  res_t             res;
  logic [WIDTH-1:0] q_next;
  logic             rco_next;
  logic             load_next;

  assign mode = mode_e'(MODO);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    q_next    = Q;
    rco_next  = 1'b0;
    load_next = 1'b0;
    res       = '0;
    if (ENABLE) begin
      case (mode)
        M_ADD_STEP: res = add_op(Q, STEP_W);
        M_INC:      res = add_op(Q, ONE_W);
        M_DEC:      res = sub_op(Q, ONE_W);
        M_SUB_STEP: res = sub_op(Q, STEP_W);
        M_LOAD:     res = '{q: D, flag: 1'b0};
        M_MOD: begin
          // Q >= LIMIT also covers entering the mode above LIMIT and LIMIT == 0.
          if (Q >= LIMIT) res = '{q: '0, flag: 1'b1};
          else            res = '{q: Q + ONE_W, flag: 1'b0};
        end
        M_HOLD, M_RSVD: res = '{q: Q, flag: 1'b0};
      endcase
      q_next    = res.q;
      rco_next  = res.flag;
      load_next = (mode == M_LOAD);
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    // NOTE: state registers use non-blocking assignments so all outputs update together.
    if (!RESET_N) begin
      Q    <= '0;
      RCO  <= 1'b0;
      LOAD <= 1'b0;
    end else begin
      Q    <= q_next;
      RCO  <= rco_next;
      LOAD <= load_next;
    end
  end

endmodule

// File: doc/contador_param.md
Name: contador_param

Overview:
- Parametrised successor to the 4-bit mode counter: WIDTH-bit synchronous up/down counter with a 3-bit mode field.
- Modes: programmable-step counting, parallel load, hold, and modulo-LIMIT counting.
- Outputs are registered Q, RCO (ripple/rollover) and LOAD flags, so a synthesised twin can be checked cycle-for-cycle by the existing counter testbench flow.

Parameters:
- WIDTH, 8, counter/data width in bits (>=2)
- STEP, 3, increment/decrement magnitude for the step modes (1 <= STEP < 2**WIDTH)

Ports:
- clk  input  1  system clock, rising edge
- RESET_N  input  1  asynchronous active-low reset
- ENABLE  input  1  count/load enable; 0 freezes Q
- MODO  input  3  operating mode (see Behaviour)
- D  input  WIDTH  parallel load value
- LIMIT  input  WIDTH  terminal value for modulo mode
- Q  output  WIDTH  counter value (registered)
- RCO  output  1  rollover flag, registered, one cycle per wrap event
- LOAD  output  1  load flag, registered, high in the cycle Q shows the loaded D

Behaviour:
- One clock (clk); reset is asynchronous and active-low (RESET_N).
- Reset:
  - RESET_N=0 forces Q=0, RCO=0, LOAD=0 immediately, without waiting for a clock edge.
  - The first rising clk edge with RESET_N=1 is the first active edge.
- All outputs update together on the rising clk edge. Latency is 1 cycle from the sampled ENABLE/MODO/D/LIMIT to Q/RCO/LOAD.
- ENABLE=0: Q holds, RCO=0, LOAD=0, regardless of MODO. ENABLE dominates MODO.
- ENABLE=1, MODO decode:
  - 000: Q <= Q+STEP
  - 001: Q <= Q-1
  - 010: Q <= Q+1
  - 011: Q <= D; LOAD=1 for that cycle; RCO=0
  - 100: Q <= Q-STEP
  - 101: hold; RCO=0, LOAD=0
  - 110: modulo count. If Q >= LIMIT, then Q <= 0 and RCO=1; else Q <= Q+1 and RCO=0.
  - 111: reserved; behaves exactly as 101.
- Arithmetic:
  - Up modes compute in WIDTH+1 bits. Carry-out means wrap: Q <= sum mod 2**WIDTH and RCO=1; otherwise RCO=0.
  - Down modes: if Q < decrement, wrap Q <= (Q - decrement) mod 2**WIDTH and RCO=1; otherwise RCO=0.
- RCO and LOAD are single-cycle pulses tied to the transition. LOAD=0 in every mode except 011.
- Boundaries:
  - Modulo mode with LIMIT=0: Q stays 0 and RCO=1 every enabled cycle.
  - Modulo mode entered with Q > LIMIT: Q <= 0 with RCO=1 on the next edge.
  - Load immediately followed by a count uses the loaded value.
  - Mode changes take effect on the very next edge, with no pipeline flush.
- Reset asserted mid-count wins over any mode. After release, counting resumes from 0.

Optional Feature:
- Macro: CONTADOR_SAT_EN.
- Defined:
  - Modes 000/010 clamp at 2**WIDTH-1 instead of wrapping.
  - Modes 001/100 clamp at 0 instead of wrapping.
  - RCO=1 in every enabled cycle where the clamp is applied, including repeated cycles at the rail.
  - Modes 011/101/110/111 are unchanged.
- Undefined: wrap-around behaviour as described above. No saturation logic is synthesised.

Test Plan (WIDTH=8, STEP=3):
- Count Q to 0x25, then pull RESET_N=0 between edges -> Q=0x00, RCO=0, LOAD=0 before the next clk edge. Release, MODO=010 -> Q=0x01 after the first edge.
- MODO=011, D=0xFD -> Q=0xFD, LOAD=1. Then MODO=000 -> Q=0x00, RCO=1, LOAD=0. Next edge -> Q=0x03, RCO=0.
- Load 0x01, MODO=001 -> Q=0x00 (RCO=0), then Q=0xFF (RCO=1). Load 0x02, MODO=100 -> Q=0xFF, RCO=1.
- LIMIT=5, Q=0, MODO=110 -> Q=1,2,3,4,5,0 with RCO=1 only on the 5->0 edge. Load 0x09, then MODO=110 -> Q=0x00, RCO=1.
- ENABLE=0, MODO=011, D=0x55 with Q=0x10 -> Q stays 0x10, LOAD=0. ENABLE=1, MODO=101 or 111 -> Q stays 0x10, RCO=0.
- CONTADOR_SAT_EN defined: load 0xFD, MODO=000 -> Q=0xFF, RCO=1, then stays 0xFF with RCO=1 each cycle. Load 0x01, MODO=100 -> Q=0x00, RCO=1.
